// File: rtl/aes_pkg.sv
// Shared constants and FSM state encoding for the AES
// masked-table precompute controller.
package aes_pkg;

    localparam int AES_NUM_ROUNDS_128 = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MASK,
        ST_PC_START,
        ST_PC_WAIT,
        ST_ROUNDS,
        ST_OUT
    } aes_state_e;

endpackage

// File: rtl/aes_precomp_ctrl.sv
// Block sequencer: refreshes masks and precomputed tables when
// needed, then drives the round datapath and result handshake.
module aes_precomp_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES_NUM_ROUNDS_128,
    parameter int REFRESH_BLOCKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       enc_dec_i,
    input  logic       flush_i,
    output logic       mask_req_o,
    input  logic       mask_ack_i,
    output logic       mask_load_o,
    output logic       pc_start_o,
    output logic       pc_enc_dec_o,
    input  logic       pc_done_i,
    output logic       round_en_o,
    output logic [3:0] round_idx_o,
    output logic       last_round_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    localparam int CW = $clog2(REFRESH_BLOCKS + 1);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    localparam logic [CW-1:0] CTR_INIT = CW'(REFRESH_BLOCKS);

    aes_state_e    state;
    logic          blk_mode;
    logic          tbl_valid;
    logic          tbl_mode;
    logic [CW-1:0] blk_ctr;
    logic          flush_pend;
    logic [3:0]    rnd_ctr;
    logic          pc_armed;
    logic          need_refresh;

    // enc_dec_i is compared directly: it becomes blk_mode this cycle
    assign need_refresh = !tbl_valid || flush_i || flush_pend
                       || (enc_dec_i != tbl_mode)
                       || (blk_ctr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            blk_mode   <= 1'b0;
            tbl_valid  <= 1'b0;
            tbl_mode   <= 1'b0;
            blk_ctr    <= '0;
            flush_pend <= 1'b0;
            rnd_ctr    <= 4'd0;
            pc_armed   <= 1'b0;
        end else begin
            if (flush_i) flush_pend <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    flush_pend <= 1'b0;
                    if (flush_i || flush_pend) tbl_valid <= 1'b0;
                    if (in_valid_i) begin
                        blk_mode <= enc_dec_i;
                        if (need_refresh) begin
                            state <= ST_MASK;
                        end else begin
                            state   <= ST_ROUNDS;
                            rnd_ctr <= 4'd1;
                        end
                    end
                end
                ST_MASK: begin
                    if (mask_ack_i) state <= ST_PC_START;
                end
                ST_PC_START: begin
                    state    <= ST_PC_WAIT;
                    pc_armed <= 1'b0;
                end
                ST_PC_WAIT: begin
                    // first wait cycle ignores a stale done
                    pc_armed <= 1'b1;
                    if (pc_armed && pc_done_i) begin
                        tbl_valid <= 1'b1;
                        tbl_mode  <= blk_mode;
                        blk_ctr   <= CTR_INIT;
                        state     <= ST_ROUNDS;
                        rnd_ctr   <= 4'd1;
                    end
                end
                ST_ROUNDS: begin
                    if (rnd_ctr == LAST) begin
                        state   <= ST_OUT;
                        rnd_ctr <= 4'd0;
                    end else begin
                        rnd_ctr <= rnd_ctr + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state      <= ST_IDLE;
                        flush_pend <= 1'b0;
                        if (flush_i || flush_pend) tbl_valid <= 1'b0;
                        if (blk_ctr != '0) blk_ctr <= blk_ctr - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o   = (state == ST_IDLE);
    assign busy_o       = (state != ST_IDLE);
    assign mask_req_o   = (state == ST_MASK);
    assign mask_load_o  = mask_req_o && mask_ack_i;
    assign pc_start_o   = (state == ST_PC_START);
    assign pc_enc_dec_o = blk_mode
                       && ((state == ST_PC_START) || (state == ST_PC_WAIT));
    assign round_en_o   = (state == ST_ROUNDS);
    assign round_idx_o  = round_en_o ? rnd_ctr : 4'd0;
    assign last_round_o = round_en_o && (rnd_ctr == LAST);
    assign out_valid_o  = (state == ST_OUT);

endmodule
